// File: rtl/sys_setup.sv
// Systolic input skew for one operand: aligns the buffer read word, zeroes bubbles, delays lane j by j+1 stages.
// Latency: ensys_i -> lane j valid is 2+j cycles. The shift is free-running with no backpressure.
module sys_setup #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             ensys_i,
  input  logic                             bubble_i,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_i,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_o,
  output logic [ARRAY_SIZE-1:0]            valid_o,
  output logic                             busy_o
);

  logic                             en_q;
  logic                             bub_q;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] word;
  logic [ARRAY_SIZE-1:0]            lane_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q  <= 1'b0;
      bub_q <= 1'b0;
    end else begin
      en_q  <= ensys_i;
      bub_q <= ensys_i & bubble_i;
    end
  end

  // The read word is only meaningful one cycle after an issued, non-bubble address.
  assign word = (en_q && !bub_q) ? data_i : '0;

  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
    logic [(j+1)*DATA_WIDTH-1:0] dsr;
    logic [j:0]                  vsr;

    if (j == 0) begin : g_first
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          dsr <= '0;
          vsr <= '0;
        end else begin
          dsr <= word[DATA_WIDTH-1:0];
          vsr <= en_q;
        end
      end
    end else begin : g_rest
      // Newest entry at the bottom; the oldest (output) stage sits in the top slot.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          dsr <= '0;
          vsr <= '0;
        end else begin
          dsr <= {dsr[j*DATA_WIDTH-1:0], word[j*DATA_WIDTH +: DATA_WIDTH]};
          vsr <= {vsr[j-1:0], en_q};
        end
      end
    end

    assign data_o[j*DATA_WIDTH +: DATA_WIDTH] = dsr[(j+1)*DATA_WIDTH-1 -: DATA_WIDTH];
    assign valid_o[j]                         = vsr[j];
    assign lane_busy[j]                       = |vsr;
  end

  assign busy_o = en_q | (|lane_busy);

endmodule

// File: tb/tb_sys_setup.sv
// Directed bench for sys_setup: per-cycle compare against a word-history model plus pinned literal checks.
module tb_sys_setup;
  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        ensys;
  logic        bubble;
  logic [63:0] data_i;
  logic [63:0] data_o;
  logic [7:0]  valid_o;
  logic        busy_o;

  int cyc      = -1;
  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  bit          ens_h [N];
  bit          bub_h [N];
  bit          rst_h [N];
  logic [63:0] dat_h [N];

  sys_setup #(.DATA_WIDTH(8), .ARRAY_SIZE(8)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .ensys_i (ensys),
    .bubble_i(bubble),
    .data_i  (data_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] ramp(input int i);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = 8'(16*i + j);
    return r;
  endfunction

  // A word issued at cycle t is still alive at cycle c if no reset touched [t, c].
  function automatic bit word_ok(input int t, input int c);
    if (t < 0) return 1'b0;
    if (!ens_h[t]) return 1'b0;
    for (int k = t; k <= c; k++) if (rst_h[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit rst, input bit ens, input bit bub, input logic [63:0] dat);
    @(posedge clk);
    cyc++;
    #1;
    rst_ni = rst;
    ensys  = ens;
    bubble = bub;
    data_i = dat;
    rst_h[cyc] = !rst;
    ens_h[cyc] = ens;
    bub_h[cyc] = bub;
    dat_h[cyc] = dat;
  endtask

  always @(negedge clk) begin : cmp
    logic [63:0] ed;
    logic [7:0]  ev;
    logic        eb;
    int          t;
    if (cyc >= 0 && !done) begin
      ed = '0;
      ev = '0;
      eb = 1'b0;
      for (int j = 0; j < 8; j++) begin
        t = cyc - 2 - j;
        if (word_ok(t, cyc)) begin
          ev[j]       = 1'b1;
          ed[j*8 +: 8] = bub_h[t] ? 8'h00 : dat_h[t+1][j*8 +: 8];
        end
      end
      for (int k = cyc - 9; k < cyc; k++) if (word_ok(k, cyc)) eb = 1'b1;
      chk("model_data", data_o, ed);
      chk("model_valid", {56'b0, valid_o}, {56'b0, ev});
      chk("model_busy", {63'b0, busy_o}, {63'b0, eb});
    end
  end

  initial begin
    rst_ni = 1'b0;
    ensys  = 1'b0;
    bubble = 1'b0;
    data_i = '0;

    // Reset state, with garbage on the inputs.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("rst_data", data_o, 64'h0);
    chk("rst_valid", {56'b0, valid_o}, 64'h0);
    chk("rst_busy", {63'b0, busy_o}, 64'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 64'h0);

    // Single word issued at i=10.
    for (int i = 0; i < 26; i++) begin
      step(1, i == 10, 0, (i == 11) ? 64'h0807_0605_0403_0201 : 64'hDEAD_BEEF_CAFE_F00D);
      if (i == 10) begin @(negedge clk); chk("single_busy_t10", {63'b0, busy_o}, 64'h0); end
      if (i == 11) begin @(negedge clk); chk("single_busy_t11", {63'b0, busy_o}, 64'h1); end
      if (i == 12) begin @(negedge clk); chk("single_data_t12", data_o, 64'h01); chk("single_valid_t12", {56'b0, valid_o}, 64'h01); end
      if (i == 15) begin @(negedge clk); chk("single_lane3_t15", {56'b0, data_o[31:24]}, 64'h04); chk("single_valid_t15", {56'b0, valid_o}, 64'h08); end
      if (i == 19) begin @(negedge clk); chk("single_data_t19", data_o, 64'h0800_0000_0000_0000); chk("single_valid_t19", {56'b0, valid_o}, 64'h80); chk("single_busy_t19", {63'b0, busy_o}, 64'h1); end
      if (i == 20) begin @(negedge clk); chk("single_busy_t20", {63'b0, busy_o}, 64'h0); end
    end

    // Stream of 8 ramp words.
    for (int i = 0; i < 22; i++) begin
      step(1, i < 8, 0, ramp(i - 1));
      if (i == 10) begin @(negedge clk); chk("stream_lane3_t10", {56'b0, data_o[31:24]}, 64'h53); chk("stream_valid_t10", {56'b0, valid_o}, 64'hFE); end
    end

    // Bubbles: 3 real words then 5 zero words.
    for (int i = 0; i < 22; i++) begin
      step(1, i < 8, (i >= 3) && (i < 8), 64'hFFFF_FFFF_FFFF_FFFF);
      if (i == 7) begin @(negedge clk); chk("bubble_data_t7", data_o, 64'h0000_FFFF_FF00_0000); chk("bubble_valid_t7", {56'b0, valid_o}, 64'h3F); end
    end

    // Garbage with ensys low and bubble toggling.
    for (int i = 0; i < 20; i++) begin
      step(1, 0, i[0], 64'hAAAA_AAAA_AAAA_AAAA);
      if (i == 19) begin @(negedge clk); chk("garbage_data", data_o, 64'h0); chk("garbage_valid", {56'b0, valid_o}, 64'h0); chk("garbage_busy", {63'b0, busy_o}, 64'h0); end
    end

    // Reset in the middle of a stream, then one word at i=10.
    for (int i = 0; i < 26; i++) begin
      step(!((i == 5) || (i == 6)), (i < 5) || (i == 10), 0, ramp(i - 1));
      if (i == 5) begin @(negedge clk); chk("midrst_data_t5", data_o, 64'h0); chk("midrst_valid_t5", {56'b0, valid_o}, 64'h0); chk("midrst_busy_t5", {63'b0, busy_o}, 64'h0); end
      if (i == 13) begin @(negedge clk); chk("midrst_lane1_t13", {56'b0, data_o[15:8]}, 64'hA1); chk("midrst_valid_t13", {56'b0, valid_o}, 64'h02); end
    end

    // Two 8-word batches with one idle cycle between them.
    for (int i = 0; i < 30; i++) begin
      step(1, (i < 8) || ((i >= 9) && (i < 17)), 0, ramp(i - 1));
      if (i == 9)  begin @(negedge clk); chk("batch_busy_t9", {63'b0, busy_o}, 64'h1); end
      if (i == 10) begin @(negedge clk); chk("batch_valid_t10", {56'b0, valid_o}, 64'hFE); chk("batch_busy_t10", {63'b0, busy_o}, 64'h1); end
      if (i == 11) begin @(negedge clk); chk("batch_valid_t11", {56'b0, valid_o}, 64'hFD); end
    end

    @(negedge clk);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
